// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the CPU MEM/WB stage
// and two DMA masters, the CCD frame writer and the NN accelerator.
// The CPU has fixed top priority and is never stalled. CCD and ACC take turns
// round-robin, and a granted master may keep ownership across a locked burst.
// Optional feature macro: DMEM_ARB_BURST_LIMIT_EN caps each ownership at
// MAX_BURST granted beats. When the macro is undefined, ownership has no limit.
module dmem_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 16,
  parameter int MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ccd_req,
  input  logic          ccd_we,
  input  logic          ccd_lock,
  input  logic [AW-1:0] ccd_addr,
  input  logic [DW-1:0] ccd_wdata,
  output logic          ccd_gnt,
  output logic          ccd_rvalid,
  output logic [DW-1:0] ccd_rdata,
  input  logic          acc_req,
  input  logic          acc_we,
  input  logic          acc_lock,
  input  logic [AW-1:0] acc_addr,
  input  logic [DW-1:0] acc_wdata,
  output logic          acc_gnt,
  output logic          acc_rvalid,
  output logic [DW-1:0] acc_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wren,
  output logic          mem_rden,
  input  logic [DW-1:0] mem_q
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_CCD = 2'd1,
    OWN_ACC = 2'd2
  } state_t;

  localparam logic WIN_CCD = 1'b0;
  localparam logic WIN_ACC = 1'b1;

  state_t state;
  state_t state_next;
  logic   last_win;
  logic   last_win_next;
  logic   cpu_acc;
  logic   burst_done;

  assign cpu_acc   = cpu_rd | cpu_wr;
  assign cpu_rdata = mem_q;
  assign ccd_rdata = mem_q;
  assign acc_rdata = mem_q;

`ifdef DMEM_ARB_BURST_LIMIT_EN
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  logic [CW-1:0] beat_cnt;

  assign burst_done = (beat_cnt == LAST_BEAT);

  // Count granted beats of the current ownership; cleared whenever the FSM heads to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (state_next == IDLE) begin
      beat_cnt <= '0;
    end else if (ccd_gnt || acc_gnt) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end
`else
  logic unused_max_burst;

  assign burst_done       = 1'b0;
  assign unused_max_burst = (MAX_BURST > 0);
`endif

  // State register and round-robin pointer (ACC after reset so CCD wins the first tie)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_win <= WIN_ACC;
    end else begin
      state    <= state_next;
      last_win <= last_win_next;
    end
  end

  // Ownership decisions and beat grants; a CPU access stalls the owner without releasing it
  always_comb begin
    state_next    = state;
    last_win_next = last_win;
    ccd_gnt       = 1'b0;
    acc_gnt       = 1'b0;
    case (state)
      IDLE: begin
        if (ccd_req && (!acc_req || (last_win == WIN_ACC))) begin
          state_next    = OWN_CCD;
          last_win_next = WIN_CCD;
        end else if (acc_req) begin
          state_next    = OWN_ACC;
          last_win_next = WIN_ACC;
        end
      end
      OWN_CCD: begin
        ccd_gnt = ccd_req & ~cpu_acc;
        if (!ccd_req) begin
          state_next = IDLE;
        end else if (ccd_gnt && (!ccd_lock || burst_done)) begin
          state_next = IDLE;
        end
      end
      OWN_ACC: begin
        acc_gnt = acc_req & ~cpu_acc;
        if (!acc_req) begin
          state_next = IDLE;
        end else if (acc_gnt && (!acc_lock || burst_done)) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Memory port mux: CPU first, then the granted master; fully quiet while in reset
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    mem_rden  = 1'b0;
    if (rst_n) begin
      if (cpu_acc) begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_wren  = cpu_wr;
        mem_rden  = cpu_rd & ~cpu_wr;
      end else if (ccd_gnt) begin
        mem_addr  = ccd_addr;
        mem_wdata = ccd_wdata;
        mem_wren  = ccd_we;
        mem_rden  = ~ccd_we;
      end else if (acc_gnt) begin
        mem_addr  = acc_addr;
        mem_wdata = acc_wdata;
        mem_wren  = acc_we;
        mem_rden  = ~acc_we;
      end
    end
  end

  // Read-valid flags track the RAM's one-cycle latency after a granted read beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccd_rvalid <= 1'b0;
      acc_rvalid <= 1'b0;
    end else begin
      ccd_rvalid <= ccd_gnt & ~ccd_we;
      acc_rvalid <= acc_gnt & ~acc_we;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors for dmem_arbiter against a behavioural
// single-port RAM with one-cycle read latency. The RAM is preloaded with
// 0xA500 | addr. Build with DMEM_ARB_BURST_LIMIT_EN to exercise the burst cap
// (MAX_BURST = 4).
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpu_rd, cpu_wr;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        ccd_req, ccd_we, ccd_lock, ccd_gnt, ccd_rvalid;
  logic [7:0]  ccd_addr;
  logic [15:0] ccd_wdata, ccd_rdata;
  logic        acc_req, acc_we, acc_lock, acc_gnt, acc_rvalid;
  logic [7:0]  acc_addr;
  logic [15:0] acc_wdata, acc_rdata;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_q;
  logic        mem_wren, mem_rden;

  int n_tests = 0;
  int n_fail  = 0;

  // cpu = {rd,wr}; ccd/acc = {req,we,lock}
  // exp_flags = {ccd_gnt, acc_gnt, ccd_rvalid, acc_rvalid, mem_wren, mem_rden}
  typedef struct {
    logic [1:0]  cpu;
    logic [7:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic [2:0]  ccd;
    logic [7:0]  ccd_addr;
    logic [15:0] ccd_wdata;
    logic [2:0]  acc;
    logic [7:0]  acc_addr;
    logic [15:0] acc_wdata;
    logic [5:0]  exp_flags;
    logic [7:0]  exp_addr;
    logic [15:0] exp_wdata;
    logic        exp_cpu_rv;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];
  vec_t seq2[$];
  vec_t seq5[$];

  dmem_arbiter #(.AW(8), .DW(16), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .ccd_req(ccd_req), .ccd_we(ccd_we), .ccd_lock(ccd_lock),
    .ccd_addr(ccd_addr), .ccd_wdata(ccd_wdata), .ccd_gnt(ccd_gnt),
    .ccd_rvalid(ccd_rvalid), .ccd_rdata(ccd_rdata),
    .acc_req(acc_req), .acc_we(acc_we), .acc_lock(acc_lock),
    .acc_addr(acc_addr), .acc_wdata(acc_wdata), .acc_gnt(acc_gnt),
    .acc_rvalid(acc_rvalid), .acc_rdata(acc_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .mem_rden(mem_rden), .mem_q(mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: preloaded on the first edge (reset is held then)
  logic [15:0] ram [0:255];
  logic        ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= 16'hA500 | 16'(i);
      ram_init <= 1'b1;
    end else begin
      if (mem_wren) ram[mem_addr] <= mem_wdata;
      if (mem_rden) mem_q <= ram[mem_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic zeroInputs();
    cpu_rd = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
    ccd_req = 0; ccd_we = 0; ccd_lock = 0; ccd_addr = 0; ccd_wdata = 0;
    acc_req = 0; acc_we = 0; acc_lock = 0; acc_addr = 0; acc_wdata = 0;
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n = 1'b0;
    zeroInputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    {cpu_rd, cpu_wr} = v.cpu;
    cpu_addr = v.cpu_addr; cpu_wdata = v.cpu_wdata;
    {ccd_req, ccd_we, ccd_lock} = v.ccd;
    ccd_addr = v.ccd_addr; ccd_wdata = v.ccd_wdata;
    {acc_req, acc_we, acc_lock} = v.acc;
    acc_addr = v.acc_addr; acc_wdata = v.acc_wdata;
    #2;
  endtask

  task automatic checkVector(input vec_t v, input string tag);
    checkOutput({tag, " ccd_gnt"},    ccd_gnt,    v.exp_flags[5]);
    checkOutput({tag, " acc_gnt"},    acc_gnt,    v.exp_flags[4]);
    checkOutput({tag, " ccd_rvalid"}, ccd_rvalid, v.exp_flags[3]);
    checkOutput({tag, " acc_rvalid"}, acc_rvalid, v.exp_flags[2]);
    checkOutput({tag, " mem_wren"},   mem_wren,   v.exp_flags[1]);
    checkOutput({tag, " mem_rden"},   mem_rden,   v.exp_flags[0]);
    checkOutput({tag, " mem_addr"},   mem_addr,   v.exp_addr);
    checkOutput({tag, " mem_wdata"},  mem_wdata,  v.exp_wdata);
    if (v.exp_flags[3]) checkOutput({tag, " ccd_rdata"}, ccd_rdata, v.exp_rdata);
    if (v.exp_flags[2]) checkOutput({tag, " acc_rdata"}, acc_rdata, v.exp_rdata);
    if (v.exp_cpu_rv)   checkOutput({tag, " cpu_rdata"}, cpu_rdata, v.exp_rdata);
  endtask

  initial begin
    int   acc_beats;
    bit   ccd_done;
    logic exp_acc, exp_ccd;

    // Main table, run straight after reset
    // Tie from reset: CCD, then ACC, then CCD again
    vecs.push_back('{2'b00, 8'h00, 16'h0000, 3'b100, 8'h01, 16'h0000, 3'b100, 8'h02, 16'h0000, 6'b000000, 8'h00, 16'h0000, 1'b0, 16'h0000});
    vecs.push_back('{2'b00, 8'h00, 16'h0000, 3'b100, 8'h01, 16'h0000, 3'b100, 8'h02, 16'h0000, 6'b100001, 8'h01, 16'h0000, 1'b0, 16'h0000});
    vecs.push_back('{2'b00, 8'h00, 16'h0000, 3'b100, 8'h03, 16'h0000, 3'b100, 8'h02, 16'h0000, 6'b001000, 8'h00, 16'h0000, 1'b0, 16'hA501});
    vecs.push_back('{2'b00, 8'h00, 16'h0000, 3'b100, 8'h03, 16'h0000, 3'b100, 8'h02, 16'h0000, 6'b010001, 8'h02, 16'h0000, 1'b0, 16'h0000});
    vecs.push_back('{2'b00, 8'h00, 16'h0000, 3'b100, 8'h03, 16'h0000, 3'b100, 8'h02, 16'h0000, 6'b000100, 8'h00, 16'h0000, 1'b0, 16'hA502});
    vecs.push_back('{2'b00, 8'h00, 16'h0000, 3'b100, 8'h03, 16'h0000, 3'b100, 8'h02, 16'h0000, 6'b100001, 8'h03, 16'h0000, 1'b0, 16'h0000});
    vecs.push_back('{2'b00, 8'h00, 16'h0000, 3'b000, 8'h00, 16'h0000, 3'b000, 8'h00, 16'h0000, 6'b001000, 8'h00, 16'h0000, 1'b0, 16'hA503});
    // CCD locked read burst 0x10..0x13
    vecs.push_back('{2'b00, 8'h00, 16'h0000, 3'b101, 8'h10, 16'h0000, 3'b000, 8'h00, 16'h0000, 6'b000000, 8'h00, 16'h0000, 1'b0, 16'h0000});
    vecs.push_back('{2'b00, 8'h00, 16'h0000, 3'b101, 8'h10, 16'h0000, 3'b000, 8'h00, 16'h0000, 6'b100001, 8'h10, 16'h0000, 1'b0, 16'h0000});
    vecs.push_back('{2'b00, 8'h00, 16'h0000, 3'b101, 8'h11, 16'h0000, 3'b000, 8'h00, 16'h0000, 6'b101001, 8'h11, 16'h0000, 1'b0, 16'hA510});
    vecs.push_back('{2'b00, 8'h00, 16'h0000, 3'b101, 8'h12, 16'h0000, 3'b000, 8'h00, 16'h0000, 6'b101001, 8'h12, 16'h0000, 1'b0, 16'hA511});
    vecs.push_back('{2'b00, 8'h00, 16'h0000, 3'b100, 8'h13, 16'h0000, 3'b000, 8'h00, 16'h0000, 6'b101001, 8'h13, 16'h0000, 1'b0, 16'hA512});
    vecs.push_back('{2'b00, 8'h00, 16'h0000, 3'b000, 8'h00, 16'h0000, 3'b000, 8'h00, 16'h0000, 6'b001000, 8'h00, 16'h0000, 1'b0, 16'hA513});
    vecs.push_back('{2'b00, 8'h00, 16'h0000, 3'b000, 8'h00, 16'h0000, 3'b000, 8'h00, 16'h0000, 6'b000000, 8'h00, 16'h0000, 1'b0, 16'h0000});
    // CPU rd+wr together is a write, then read back
    vecs.push_back('{2'b11, 8'h05, 16'h1234, 3'b000, 8'h00, 16'h0000, 3'b000, 8'h00, 16'h0000, 6'b000010, 8'h05, 16'h1234, 1'b0, 16'h0000});
    vecs.push_back('{2'b10, 8'h05, 16'h0000, 3'b000, 8'h00, 16'h0000, 3'b000, 8'h00, 16'h0000, 6'b000001, 8'h05, 16'h0000, 1'b0, 16'h0000});
    vecs.push_back('{2'b00, 8'h00, 16'h0000, 3'b000, 8'h00, 16'h0000, 3'b000, 8'h00, 16'h0000, 6'b000000, 8'h00, 16'h0000, 1'b1, 16'h1234});
    // ACC single write beat, CPU reads it back
    vecs.push_back('{2'b00, 8'h00, 16'h0000, 3'b000, 8'h00, 16'h0000, 3'b110, 8'h30, 16'h5555, 6'b000000, 8'h00, 16'h0000, 1'b0, 16'h0000});
    vecs.push_back('{2'b00, 8'h00, 16'h0000, 3'b000, 8'h00, 16'h0000, 3'b110, 8'h30, 16'h5555, 6'b010010, 8'h30, 16'h5555, 1'b0, 16'h0000});
    vecs.push_back('{2'b10, 8'h30, 16'h0000, 3'b000, 8'h00, 16'h0000, 3'b000, 8'h00, 16'h0000, 6'b000001, 8'h30, 16'h0000, 1'b0, 16'h0000});
    vecs.push_back('{2'b00, 8'h00, 16'h0000, 3'b000, 8'h00, 16'h0000, 3'b000, 8'h00, 16'h0000, 6'b000000, 8'h00, 16'h0000, 1'b1, 16'h5555});

    // CPU store/load interleaved with a CCD locked burst
    seq2.push_back('{2'b00, 8'h00, 16'h0000, 3'b101, 8'h40, 16'h0000, 3'b000, 8'h00, 16'h0000, 6'b000000, 8'h00, 16'h0000, 1'b0, 16'h0000});
    seq2.push_back('{2'b00, 8'h00, 16'h0000, 3'b101, 8'h40, 16'h0000, 3'b000, 8'h00, 16'h0000, 6'b100001, 8'h40, 16'h0000, 1'b0, 16'h0000});
    seq2.push_back('{2'b01, 8'h20, 16'hBEEF, 3'b101, 8'h41, 16'h0000, 3'b000, 8'h00, 16'h0000, 6'b001010, 8'h20, 16'hBEEF, 1'b0, 16'hA540});
    seq2.push_back('{2'b10, 8'h20, 16'h0000, 3'b100, 8'h41, 16'h0000, 3'b000, 8'h00, 16'h0000, 6'b000001, 8'h20, 16'h0000, 1'b0, 16'h0000});
    seq2.push_back('{2'b00, 8'h00, 16'h0000, 3'b100, 8'h41, 16'h0000, 3'b000, 8'h00, 16'h0000, 6'b100001, 8'h41, 16'h0000, 1'b1, 16'hBEEF});
    seq2.push_back('{2'b00, 8'h00, 16'h0000, 3'b000, 8'h00, 16'h0000, 3'b000, 8'h00, 16'h0000, 6'b001000, 8'h00, 16'h0000, 1'b0, 16'hA541});

    // Reset mid ACC read: first the owned beat, then the tie after release
    seq5.push_back('{2'b00, 8'h00, 16'h0000, 3'b000, 8'h00, 16'h0000, 3'b101, 8'h50, 16'h0000, 6'b000000, 8'h00, 16'h0000, 1'b0, 16'h0000});
    seq5.push_back('{2'b00, 8'h00, 16'h0000, 3'b000, 8'h00, 16'h0000, 3'b101, 8'h50, 16'h0000, 6'b010001, 8'h50, 16'h0000, 1'b0, 16'h0000});
    seq5.push_back('{2'b00, 8'h00, 16'h0000, 3'b100, 8'h60, 16'h0000, 3'b100, 8'h61, 16'h0000, 6'b000000, 8'h00, 16'h0000, 1'b0, 16'h0000});
    seq5.push_back('{2'b00, 8'h00, 16'h0000, 3'b100, 8'h60, 16'h0000, 3'b100, 8'h61, 16'h0000, 6'b100001, 8'h60, 16'h0000, 1'b0, 16'h0000});

    // Reset state: outputs quiet even with a CPU store driven
    rst_n = 1'b0;
    zeroInputs();
    cpu_wr = 1'b1; cpu_rd = 1'b1; cpu_addr = 8'h07;
    repeat (2) @(negedge clk);
    #2;
    checkOutput("reset ccd_gnt",    ccd_gnt,    1'b0);
    checkOutput("reset acc_gnt",    acc_gnt,    1'b0);
    checkOutput("reset ccd_rvalid", ccd_rvalid, 1'b0);
    checkOutput("reset acc_rvalid", acc_rvalid, 1'b0);
    checkOutput("reset mem_wren",   mem_wren,   1'b0);
    checkOutput("reset mem_rden",   mem_rden,   1'b0);
    @(negedge clk);
    zeroInputs();
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkVector(vecs[i], $sformatf("vec%0d", i));
    end

    resetDut();
    for (int i = 0; i < seq2.size(); i++) begin
      applyStimulus(seq2[i]);
      checkVector(seq2[i], $sformatf("cpu_stall%0d", i));
    end

    // ACC locked 10-beat burst while CCD waits
    resetDut();
    acc_beats = 0;
    ccd_done  = 1'b0;
    for (int s = 0; s <= 12; s++) begin
      @(negedge clk);
      cpu_rd = 0; cpu_wr = 0;
      acc_req  = (acc_beats < 10);
      acc_we   = 1'b0;
      acc_lock = (acc_beats < 9);
      acc_addr = 8'h70 + 8'(acc_beats);
      ccd_req  = (s >= 1) && !ccd_done;
      ccd_we   = 1'b0;
      ccd_lock = 1'b0;
      ccd_addr = 8'h7F;
      #2;
`ifdef DMEM_ARB_BURST_LIMIT_EN
      exp_acc = ((s >= 1) && (s <= 4)) || ((s >= 8) && (s <= 11));
      exp_ccd = (s == 6);
`else
      exp_acc = (s >= 1) && (s <= 10);
      exp_ccd = (s == 12);
`endif
      checkOutput($sformatf("burst%0d acc_gnt", s), acc_gnt, exp_acc);
      checkOutput($sformatf("burst%0d ccd_gnt", s), ccd_gnt, exp_ccd);
      if (acc_gnt) acc_beats++;
      if (ccd_gnt) ccd_done = 1'b1;
    end

    // Reset pulse while an ACC read beat is being granted
    resetDut();
    applyStimulus(seq5[0]);
    checkVector(seq5[0], "rst_mid0");
    applyStimulus(seq5[1]);
    checkVector(seq5[1], "rst_mid1");
    rst_n    = 1'b0;
    cpu_rd   = 1'b1;
    cpu_addr = 8'h50;
    #1;
    checkOutput("rst_mid acc_gnt",  acc_gnt,  1'b0);
    checkOutput("rst_mid mem_rden", mem_rden, 1'b0);
    checkOutput("rst_mid mem_wren", mem_wren, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("rst_mid acc_rvalid", acc_rvalid, 1'b0);
    @(negedge clk);
    zeroInputs();
    rst_n = 1'b1;
    #1;
    checkOutput("rst_rel acc_rvalid", acc_rvalid, 1'b0);
    applyStimulus(seq5[2]);
    checkVector(seq5[2], "rst_tie0");
    applyStimulus(seq5[3]);
    checkVector(seq5[3], "rst_tie1");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
